// File: rtl/mac_cfg_seq.sv
// Configuration sequencer that walks NUM_PE MAC PEs and writes bits_peek, xmid and m over a shared cfg bus.
// Optional feature macro MAC_CFG_SEQ_SKIP_CLEAN_EN: when defined, the sequencer tracks dirty state and skips registers that have not changed.
module mac_cfg_seq #(
  parameter int                           NOC_WID           = 16,
  parameter int                           REGIONAL_ADDR_WID = 11,
  parameter int                           NUM_PE            = 4,
  parameter logic [REGIONAL_ADDR_WID-1:0] BASE_ADR          = 11'h040,
  parameter int                           PE_STRIDE         = 16,
  parameter logic [REGIONAL_ADDR_WID-1:0] IDLE_ADR          = 11'h7FF,
  parameter int                           HOLD_CYC          = 2,
  localparam int                          IDX_W             = $clog2(NUM_PE + 1),
  localparam int                          PE_W              = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
  localparam int                          HOLD_W            = $clog2(HOLD_CYC + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NOC_WID-1:0]           bits_peek,
  input  logic [NOC_WID-1:0]           xmid,
  input  logic                         m_wr_en,
  input  logic [IDX_W-1:0]             m_wr_idx,
  input  logic [NOC_WID-1:0]           m_wr_dat,
  output logic                         m_wr_err,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [NOC_WID-1:0]           cfg_dat,
  output logic [REGIONAL_ADDR_WID-1:0] cfg_adr
);

  localparam int NUM_W = 3 * NUM_PE;

  typedef enum logic [2:0] {S_IDLE, S_EVAL, S_WR, S_GAP, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [PE_W-1:0]                pe_q, pe_d;
  logic [1:0]                     f_q, f_d;
  logic [HOLD_W-1:0]              hold_q, hold_d;
  logic [NOC_WID-1:0]             sh_peek, sh_xmid;
  logic [NOC_WID-1:0]             m_tab [NUM_PE];
  logic [NUM_W-1:0]               need;
  logic                           m_wr_ok;
  int                             search_from;
  logic                           nxt_found;
  logic [PE_W-1:0]                nxt_pe;
  logic [1:0]                     nxt_f;
  logic                           busy_d, done_d, m_wr_err_d;
  logic [NOC_WID-1:0]             cfg_dat_d;
  logic [REGIONAL_ADDR_WID-1:0]   cfg_adr_d;

  // The m table may only change while idle, so a running sequence always sees a stable snapshot.
  assign m_wr_ok = m_wr_en && (state_q == S_IDLE) && (m_wr_idx < IDX_W'(NUM_PE));

`ifdef MAC_CFG_SEQ_SKIP_CLEAN_EN
  logic [NUM_PE-1:0]  m_dirty;
  logic               sh_dirty_q, sh_dirty;
  logic [NOC_WID-1:0] last_peek, last_xmid;

  assign sh_dirty = sh_dirty_q || (sh_peek != last_peek) || (sh_xmid != last_xmid);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_dirty    <= '1;
      sh_dirty_q <= 1'b1;
      last_peek  <= '0;
      last_xmid  <= '0;
    end else if (state_q == S_DONE) begin
      m_dirty    <= '0;
      sh_dirty_q <= 1'b0;
      last_peek  <= sh_peek;
      last_xmid  <= sh_xmid;
    end else if (m_wr_ok) begin
      m_dirty[m_wr_idx[PE_W-1:0]] <= 1'b1;
    end
  end

  always_comb begin
    need = '0;
    for (int i = 0; i < NUM_W; i++)
      need[i] = (i % 3 == 2) ? m_dirty[i / 3] : sh_dirty;
  end
`else
  assign need = '1;
`endif

  // NOTE: the m table is a small register file with a defined power-up value, not a RAM, so clearing it on rst is intended.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PE; i++) m_tab[i] <= '0;
    end else if (m_wr_ok) begin
      m_tab[m_wr_idx[PE_W-1:0]] <= m_wr_dat;
    end
  end

  // Find the next (pe, field) slot that needs a write; slots are ordered pe*3+f.
  always_comb begin
    search_from = (state_q == S_GAP) ? int'(pe_q) * 3 + int'(f_q) + 1 : 0;
    nxt_found   = 1'b0;
    nxt_pe      = '0;
    nxt_f       = '0;
    for (int i = 0; i < NUM_W; i++) begin
      if (!nxt_found && i >= search_from && need[i]) begin
        nxt_found = 1'b1;
        nxt_pe    = PE_W'(i / 3);
        nxt_f     = 2'(i % 3);
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    pe_d    = pe_q;
    f_d     = f_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef MAC_CFG_SEQ_SKIP_CLEAN_EN
          state_d = S_EVAL;
`else
          state_d = S_WR;
          pe_d    = '0;
          f_d     = '0;
          hold_d  = HOLD_W'(1);
`endif
        end
      end
      S_EVAL, S_GAP: begin
        if (nxt_found) begin
          state_d = S_WR;
          pe_d    = nxt_pe;
          f_d     = nxt_f;
          hold_d  = HOLD_W'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_WR: begin
        if (hold_q == HOLD_W'(HOLD_CYC)) state_d = S_GAP;
        else                             hold_d  = hold_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so cfg_adr only ever moves IDLE_ADR <-> one PE address.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    m_wr_err_d = m_wr_en && !m_wr_ok;
    cfg_adr_d  = IDLE_ADR;
    cfg_dat_d  = '0;
    if (state_d == S_WR) begin
      cfg_adr_d = BASE_ADR + REGIONAL_ADDR_WID'(int'(pe_d) * PE_STRIDE + 4 * int'(f_d));
      unique case (f_d)
        2'd0:    cfg_dat_d = (state_q == S_IDLE) ? bits_peek : sh_peek;
        2'd1:    cfg_dat_d = sh_xmid;
        default: cfg_dat_d = m_tab[pe_d];
      endcase
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pe_q     <= '0;
      f_q      <= '0;
      hold_q   <= '0;
      sh_peek  <= '0;
      sh_xmid  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      m_wr_err <= 1'b0;
      cfg_adr  <= IDLE_ADR;
      cfg_dat  <= '0;
    end else begin
      state_q  <= state_d;
      pe_q     <= pe_d;
      f_q      <= f_d;
      hold_q   <= hold_d;
      busy     <= busy_d;
      done     <= done_d;
      m_wr_err <= m_wr_err_d;
      cfg_adr  <= cfg_adr_d;
      cfg_dat  <= cfg_dat_d;
      if (state_q == S_IDLE && start) begin
        sh_peek <= bits_peek;
        sh_xmid <= xmid;
      end
    end
  end

endmodule
